// File: rtl/serial_slice_adder.sv
// serial_slice_adder: WIDTH-bit a+b+carryin computed SLICE bits per clock through a registered carry,
// with valid/ready handshakes and a signed-overflow flag.
module serial_slice_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  if (SLICE < 1 || SLICE > WIDTH || WIDTH % SLICE != 0) begin : g_bad_params
    $error("serial_slice_adder: WIDTH must be a positive multiple of SLICE");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_c, r_cout, r_ovf;
  logic [KW-1:0]    r_k;
  logic [SLICE:0]   w_add;
  logic             w_last;
  assign w_add  = {1'b0, r_a[r_k*SLICE +: SLICE]} + {1'b0, r_b[r_k*SLICE +: SLICE]} + (SLICE+1)'(r_c);
  assign w_last = r_k == KW'(N - 1);
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign sum       = r_sum;
  assign carryout  = r_cout;
  assign overflow  = r_ovf;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (in_valid ? RUN : IDLE)
           : r_state == RUN  ? (w_last ? DONE : RUN)
           : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // The MSB's carry-in is recovered from its operand bits and sum bit: a^b^s.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_k    <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_a <= a;
      r_b <= b;
      r_c <= carryin;
      r_k <= '0;
    end else if (r_state == RUN) begin
      r_sum[r_k*SLICE +: SLICE] <= w_add[SLICE-1:0];
      r_c <= w_add[SLICE];
      r_k <= r_k + 1'b1;
      if (w_last) begin
        r_cout <= w_add[SLICE];
        r_ovf  <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_add[SLICE-1] ^ w_add[SLICE];
      end
    end
endmodule

// File: tb/tb_serial_slice_adder.sv
// tb_serial_slice_adder: directed vectors on 32/4 and 1/1 instances plus a randomized
// handshake sweep over WIDTH=16 with every legal SLICE, checked against arithmetic.
module tb_serial_slice_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_tests = 0;
  int n_fail = 0;
  int sweep_done = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  logic        rst_n, rst_sw;
  logic        m_iv, m_ir, m_ci, m_ov, m_or, m_co, m_of;
  logic [31:0] m_a, m_b, m_s;
  serial_slice_adder #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir), .a(m_a), .b(m_b),
    .carryin(m_ci), .out_valid(m_ov), .out_ready(m_or), .sum(m_s), .carryout(m_co),
    .overflow(m_of));
  logic w_iv, w_ir, w_ci, w_ov, w_or, w_co, w_of;
  logic [0:0] w_a, w_b, w_s;
  serial_slice_adder #(.WIDTH(1), .SLICE(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_iv), .in_ready(w_ir), .a(w_a), .b(w_b),
    .carryin(w_ci), .out_valid(w_ov), .out_ready(w_or), .sum(w_s), .carryout(w_co),
    .overflow(w_of));
  for (genvar g = 0; g < 5; g++) begin : g_sw
    localparam int SL = 1 << g;
    localparam int NN = 16 / SL;
    logic        iv, ir, ci, ov, ordy, co, of;
    logic [15:0] a, b, s;
    serial_slice_adder #(.WIDTH(16), .SLICE(SL)) dut_sw (
      .clk(clk), .rst_n(rst_sw), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
      .carryin(ci), .out_valid(ov), .out_ready(ordy), .sum(s), .carryout(co),
      .overflow(of));
    initial begin
      bit          busy, acc, cons;
      int          j, ops;
      logic [15:0] ea, eb;
      logic        ec;
      logic [16:0] r_exp;
      busy = 0; acc = 0; cons = 0; j = 0; ops = 0;
      iv = 0; ordy = 0; a = 0; b = 0; ci = 0; ea = 0; eb = 0; ec = 0;
      @(posedge rst_sw);
      for (int cyc = 0; cyc < 40000 && ops < 300; cyc++) begin
        @(negedge clk);
        if (cons) begin busy = 0; ops++; end
        if (acc) begin busy = 1; j = 0; end
        else if (busy) j++;
        chk($sformatf("sw%0d in_ready", SL), 64'(ir), 64'(!busy));
        chk($sformatf("sw%0d out_valid", SL), 64'(ov), 64'(busy && j >= NN));
        if (busy && j >= NN) begin
          r_exp = {1'b0, ea} + {1'b0, eb} + 17'(ec);
          chk($sformatf("sw%0d sum", SL), 64'(s), 64'(r_exp[15:0]));
          chk($sformatf("sw%0d carryout", SL), 64'(co), 64'(r_exp[16]));
          chk($sformatf("sw%0d overflow", SL), 64'(of),
              64'(ea[15] == eb[15] && r_exp[15] != ea[15]));
        end
        iv = 1'($urandom); ordy = 1'($urandom);
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
        acc  = iv && !busy;
        cons = ordy && busy && j >= NN;
        if (acc) begin ea = a; eb = b; ec = ci; end
      end
      chk($sformatf("sw%0d ops", SL), 64'(ops), 64'd300);
      sweep_done++;
    end
  end
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci, output int lat);
    @(negedge clk);
    chk("run_op in_ready", 64'(m_ir), 64'd1);
    m_a = a; m_b = b; m_ci = ci; m_iv = 1'b1;
    @(negedge clk);
    m_iv = 1'b0; m_a = ~a; m_b = $urandom; m_ci = ~ci;
    lat = 0;
    while (!m_ov && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic consume();
    m_or = 1'b1;
    @(negedge clk);
    m_or = 1'b0;
    chk("consume in_ready", 64'(m_ir), 64'd1);
    chk("consume out_valid", 64'(m_ov), 64'd0);
  endtask
  typedef struct {
    logic [31:0] a, b;
    logic        ci;
    logic [31:0] s;
    logic        co, of;
  } vec_t;
  typedef struct {
    logic [2:0] abc;
    logic [1:0] cs;
    logic       of;
  } fa_t;
  initial begin
    vec_t tv[7];
    fa_t  fa[8];
    int   lat;
    tv[0] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    tv[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tv[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tv[3] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    tv[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tv[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    tv[6] = '{32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0};
    fa[0] = '{3'b000, 2'd0, 1'b0};
    fa[1] = '{3'b001, 2'd1, 1'b1};
    fa[2] = '{3'b010, 2'd1, 1'b0};
    fa[3] = '{3'b011, 2'd2, 1'b0};
    fa[4] = '{3'b100, 2'd1, 1'b0};
    fa[5] = '{3'b101, 2'd2, 1'b0};
    fa[6] = '{3'b110, 2'd2, 1'b1};
    fa[7] = '{3'b111, 2'd3, 1'b0};
    rst_n = 0; rst_sw = 0;
    m_iv = 0; m_or = 0; m_a = 0; m_b = 0; m_ci = 0;
    w_iv = 0; w_or = 0; w_a = 0; w_b = 0; w_ci = 0;
    @(negedge clk);
    chk("reset in_ready", 64'(m_ir), 64'd1);
    chk("reset out_valid", 64'(m_ov), 64'd0);
    chk("reset sum", 64'(m_s), 64'd0);
    chk("reset carryout", 64'(m_co), 64'd0);
    chk("reset overflow", 64'(m_of), 64'd0);
    @(negedge clk);
    rst_n = 1; rst_sw = 1;
    for (int i = 0; i < 7; i++) begin
      run_op(tv[i].a, tv[i].b, tv[i].ci, lat);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd8);
      chk($sformatf("vec%0d sum", i), 64'(m_s), 64'(tv[i].s));
      chk($sformatf("vec%0d carryout", i), 64'(m_co), 64'(tv[i].co));
      chk($sformatf("vec%0d overflow", i), 64'(m_of), 64'(tv[i].of));
      consume();
    end
    // Backpressure: result must hold while inputs churn and in_valid is pulsed.
    run_op(32'h89ABCDEF, 32'h01234567, 1'b1, lat);
    chk("bp latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      m_a = $urandom; m_b = $urandom; m_ci = 1'($urandom); m_iv = 1'b1;
      @(negedge clk);
      chk("bp sum", 64'(m_s), 64'h8ACF1357);
      chk("bp carryout", 64'(m_co), 64'd0);
      chk("bp in_ready", 64'(m_ir), 64'd0);
      chk("bp out_valid", 64'(m_ov), 64'd1);
    end
    m_iv = 1'b0;
    consume();
    @(negedge clk);
    chk("bp idle out_valid", 64'(m_ov), 64'd0);
    m_a = 32'hFFFFFFFF; m_b = 32'hFFFFFFFF; m_ci = 1'b1; m_iv = 1'b1;
    @(negedge clk);
    m_iv = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun in_ready", 64'(m_ir), 64'd1);
    chk("midrun out_valid", 64'(m_ov), 64'd0);
    chk("midrun sum", 64'(m_s), 64'd0);
    chk("midrun carryout", 64'(m_co), 64'd0);
    chk("midrun overflow", 64'(m_of), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h12345678, 32'h11111111, 1'b0, lat);
    chk("post-reset latency", 64'(lat), 64'd8);
    chk("post-reset sum", 64'(m_s), 64'h23456789);
    consume();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {w_a, w_b, w_ci} = fa[i].abc;
      w_iv = 1'b1;
      @(negedge clk);
      w_iv = 1'b0;
      lat = 0;
      while (!w_ov && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("fa%0d latency", i), 64'(lat), 64'd1);
      chk($sformatf("fa%0d cout_sum", i), 64'({w_co, w_s}), 64'(fa[i].cs));
      chk($sformatf("fa%0d overflow", i), 64'(w_of), 64'(fa[i].of));
      w_or = 1'b1;
      @(negedge clk);
      w_or = 1'b0;
      chk($sformatf("fa%0d in_ready", i), 64'(w_ir), 64'd1);
    end
    for (int t = 0; t < 60000 && sweep_done < 5; t++) @(negedge clk);
    chk("sweep finished", 64'(sweep_done), 64'd5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_slice_adder.md
# serial_slice_adder

Multi-cycle parametrised adder: adds two WIDTH-bit operands plus a carry-in, SLICE bits per clock, through a registered carry chain. It generalises the one-bit full adder into a width-configurable, throughput/area-tunable datapath block with valid/ready handshakes on input and output, plus a signed-overflow flag. It sits between operand registers and any consumer that can tolerate WIDTH/SLICE cycles of latency in exchange for a SLICE-bit adder.

## Interface
- WIDTH, 32: operand/sum width in bits; ≥1.
- SLICE, 4: bits added per cycle; 1 ≤ SLICE ≤ WIDTH, WIDTH % SLICE == 0 (elaboration error otherwise).
- N (derived, localparam) = WIDTH/SLICE: number of slice steps.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- carryin  in  1  carry into bit 0.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  (a + b + carryin) mod 2^WIDTH.
- carryout  out  1  carry out of bit WIDTH-1.
- overflow  out  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- States: IDLE, RUN, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- IDLE: on in_valid && in_ready, latch a, b, and carryin into internal registers; clear slice counter; go to RUN. Otherwise stay.
- RUN: each cycle, add slice k (bits k*SLICE+SLICE-1 .. k*SLICE) of the latched a and b plus the registered carry. Write the result into sum bits of slice k. Register the slice carry-out. Increment k.
  - On the last slice (k == N-1), also compute overflow from the carry into the MSB and carryout. Go to DONE.
- DONE: hold sum, carryout, and overflow stable. On out_ready, go to IDLE.
- sum, carryout, and overflow keep their last values in IDLE. They are overwritten slice by slice during the next RUN. They are valid only while out_valid=1.
- One operation in flight. Input port changes after acceptance have no effect. in_valid is ignored outside IDLE.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, counter=0, internal carry=0.
  - sum=0, carryout=0, overflow=0, out_valid=0; in_ready=1 immediately.
  - An in-flight operation is discarded with no output.
- WIDTH=SLICE (N=1) is legal: a single RUN cycle.

## Timing
- Accept edge = rising edge with in_valid && in_ready. out_valid rises exactly N edges after the accept edge (defaults: 8).
- Result consumed on the edge with out_valid && out_ready. in_ready rises the cycle after. No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Minimum issue interval: N+2 cycles with out_ready held high (accept, N RUN, DONE).
- All outputs are registered or decoded from state registers only.
- Critical path: one SLICE-bit adder plus a carry register.

## Test plan
- Defaults: a=0, b=0, carryin=0 -> out_valid exactly 8 cycles after accept; sum=0, carryout=0, overflow=0.
- a=32'hFFFFFFFF, b=0, carryin=1 -> sum=0, carryout=1, overflow=0. Also a=32'h7FFFFFFF, b=1, carryin=0 -> sum=32'h80000000, carryout=0, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while changing a/b and pulsing in_valid.
  - Required: sum/carryout stay stable; in_ready=0; no new operation accepted.
  - After out_ready=1, in_ready=1 on the next cycle.
- Reset mid-RUN (assert rst_n=0 after 3 RUN cycles, between edges) -> outputs zero immediately; in_ready=1. The next operation, a=32'h12345678, b=32'h11111111, returns sum=32'h23456789.
- WIDTH=1, SLICE=1: all 8 (a, b, carryin) combinations -> {carryout, sum} match the full-adder truth table; latency 1 cycle.
- Random sweep, WIDTH=16, SLICE ∈ {1, 2, 4, 8, 16}, ≥1000 ops with random in_valid/out_ready -> every result equals a + b + carryin; latency = N.
